// File: rtl/ysyx_23060061_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : ysyx_23060061_fetch_unit
// Description : Instruction fetch stage: owns the PC, fetches over a
//               valid/ready port and holds the instruction in IR for decode.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060061_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] pc,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] br_target,
  input  logic            halt,
  output logic            fetch_fault,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [31:0]     NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  // Keeps the request low during and directly after reset even though the
  // reset state is already REQ.
  logic            req_en_q;
  logic [XLEN-1:0] next_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC[XLEN-1:0];
      ir_q     <= NOP_INST;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      req_en_q <= 1'b1;
    end
  end

  assign next_pc = pc_sel ? br_target : (pc_q + PC_STEP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_REQ: begin
        if (req_en_q && imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = S_FAULT;
          end else begin
            ir_d    = imem_rsp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          if (halt) begin
            state_d = S_HALT;
          end else if (next_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ) && req_en_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = ir_q;
  assign pc             = pc_q;
  assign opcode         = ir_q[6:0];
  assign funct3         = ir_q[14:12];
  assign funct7         = ir_q[31:25];
  assign fetch_fault    = (state_q == S_FAULT);
  assign halted         = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060061_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_ysyx_23060061_fetch_unit
// Description : Directed self-checking bench for the fetch unit.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_23060061_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready, imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        inst_ready, pc_sel, halt;
  logic [31:0] br_target;

  logic        req_valid, inst_valid, fetch_fault, halted;
  logic [31:0] req_addr, inst, pc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  // Second instance with a wrap-around reset PC; shares all inputs.
  logic        w_req_valid, w_inst_valid, w_fetch_fault, w_halted;
  logic [31:0] w_req_addr, w_inst, w_pc;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] I_ADDI   = 32'h0010_0093;
  localparam logic [31:0] I_ADD    = 32'h0020_81B3;
  localparam logic [31:0] I_SW     = 32'h0030_A023;
  localparam logic [31:0] I_SUB    = 32'h4020_8133;
  localparam logic [31:0] I_JAL    = 32'h0000_006F;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  always #5 clk = ~clk;

  ysyx_23060061_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .pc(pc),
    .pc_sel(pc_sel), .br_target(br_target), .halt(halt),
    .fetch_fault(fetch_fault), .halted(halted)
  );

  ysyx_23060061_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .XLEN(32)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst(w_inst),
    .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7), .pc(w_pc),
    .pc_sel(pc_sel), .br_target(br_target), .halt(halt),
    .fetch_fault(w_fetch_fault), .halted(w_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    imem_rsp_data = 32'h0; inst_ready = 1'b0; pc_sel = 1'b0; halt = 1'b0; br_target = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // From REQ with ready high: handshake, then one-cycle response.
  task automatic fetch(input logic [31:0] data, input logic err);
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = data; imem_rsp_err = err;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
  endtask

  task automatic accept(input logic sel, input logic [31:0] tgt, input logic hlt);
    inst_ready = 1'b1; pc_sel = sel; br_target = tgt; halt = hlt;
    tick();
    inst_ready = 1'b0; pc_sel = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    imem_rsp_data = 32'h0; inst_ready = 1'b0; pc_sel = 1'b0; halt = 1'b0; br_target = 32'h0;
    tick(); tick();
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
    n_cmp++; if (pc !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_pc got %h want 80000000", pc); end
    n_cmp++; if (inst !== 32'h0000_0013) begin n_bad++; $display("FAIL reset_inst got %h want 00000013", inst); end
    n_cmp++; if ({fetch_fault, halted} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {fetch_fault, halted}); end
    rst = 1'b0;
    tick();
    n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL first_req got v=%b a=%h want v=1 a=80000000", req_valid, req_addr); end
    tick();
    n_cmp++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL wait_state got rv=%b iv=%b want 0 0", req_valid, inst_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = I_ADDI;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || inst !== I_ADDI) begin n_bad++; $display("FAIL first_inst got v=%b i=%h want v=1 i=%h", inst_valid, inst, I_ADDI); end
  endtask

  task automatic test_sequential();
    apply_reset();
    fetch(I_ADDI, 1'b0);
    n_cmp++; if (pc !== 32'h8000_0000 || opcode !== 7'h13) begin n_bad++; $display("FAIL seq0 got pc=%h op=%h want 80000000 13", pc, opcode); end
    accept(1'b0, 32'h0, 1'b0);
    n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL seq1_req got v=%b a=%h want 1 80000004", req_valid, req_addr); end
    fetch(I_ADD, 1'b0);
    n_cmp++; if (pc !== 32'h8000_0004 || opcode !== 7'h33) begin n_bad++; $display("FAIL seq1 got pc=%h op=%h want 80000004 33", pc, opcode); end
    accept(1'b0, 32'h0, 1'b0);
    fetch(I_SW, 1'b0);
    n_cmp++; if (pc !== 32'h8000_0008 || opcode !== 7'h23 || funct3 !== 3'd2) begin n_bad++; $display("FAIL seq2 got pc=%h op=%h f3=%0d want 80000008 23 2", pc, opcode, funct3); end
    accept(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_backpressure_branch();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_000C) begin n_bad++; $display("FAIL bp_req%0d got v=%b a=%h want 1 8000000c", i, req_valid, req_addr); end
    end
    fetch(I_SUB, 1'b0);
    n_cmp++; if (funct7 !== 7'h20 || opcode !== 7'h33) begin n_bad++; $display("FAIL sub_slices got f7=%h op=%h want 20 33", funct7, opcode); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (inst_valid !== 1'b1 || inst !== I_SUB || pc !== 32'h8000_000C || req_valid !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d got iv=%b i=%h pc=%h rv=%b want 1 %h 8000000c 0", i, inst_valid, inst, pc, req_valid, I_SUB);
      end
    end
    accept(1'b1, 32'h8000_0100, 1'b0);
    n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0100) begin n_bad++; $display("FAIL branch_req got v=%b a=%h want 1 80000100", req_valid, req_addr); end
    fetch(I_JAL, 1'b0);
    accept(1'b1, 32'h8000_0102, 1'b0);
    tick(); tick();
    n_cmp++; if (fetch_fault !== 1'b1 || req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL misalign got ff=%b rv=%b iv=%b want 1 0 0", fetch_fault, req_valid, inst_valid); end
    n_cmp++; if (pc !== 32'h8000_0100) begin n_bad++; $display("FAIL misalign_pc got %h want 80000100", pc); end
  endtask

  task automatic test_halt();
    apply_reset();
    fetch(I_EBREAK, 1'b0);
    accept(1'b1, 32'h8000_0200, 1'b1);
    tick();
    n_cmp++; if (halted !== 1'b1 || inst_valid !== 1'b0 || req_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      n_bad++; $display("FAIL halt got h=%b iv=%b rv=%b ff=%b want 1 0 0 0", halted, inst_valid, req_valid, fetch_fault);
    end
    n_cmp++; if (pc !== 32'h8000_0000) begin n_bad++; $display("FAIL halt_pc got %h want 80000000", pc); end
  endtask

  task automatic test_error_wrap();
    apply_reset();
    fetch(I_ADDI, 1'b0);
    accept(1'b0, 32'h0, 1'b0);
    n_cmp++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_req got v=%b a=%h want 1 00000000", w_req_valid, w_req_addr); end
    fetch(32'hDEAD_BEEF, 1'b1);
    n_cmp++; if (fetch_fault !== 1'b1 || inst !== I_ADDI || inst_valid !== 1'b0) begin n_bad++; $display("FAIL rsp_err got ff=%b i=%h iv=%b want 1 %h 0", fetch_fault, inst, inst_valid, I_ADDI); end
    tick();
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL err_no_req got %b want 0", req_valid); end
    // Reset in the middle of WAIT, then a stale response arriving in REQ.
    apply_reset();
    fetch(I_ADDI, 1'b0);
    accept(1'b0, 32'h0, 1'b0);
    imem_req_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (pc !== 32'h8000_0000 || inst !== 32'h0000_0013 || inst_valid !== 1'b0 || req_valid !== 1'b0) begin
      n_bad++; $display("FAIL midwait_rst got pc=%h i=%h iv=%b rv=%b want 80000000 00000013 0 0", pc, inst, inst_valid, req_valid);
    end
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = I_ADD;
    tick();
    imem_rsp_valid = 1'b0;
    tick();
    n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || inst_valid !== 1'b0 || inst !== 32'h0000_0013) begin
      n_bad++; $display("FAIL stale_rsp got rv=%b a=%h iv=%b i=%h want 1 80000000 0 00000013", req_valid, req_addr, inst_valid, inst);
    end
  endtask

  initial begin
    test_reset();
    accept(1'b0, 32'h0, 1'b0);
    test_sequential();
    test_backpressure_branch();
    test_halt();
    test_error_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
